// File: rtl/crg_ctrl_pkg.sv
// Shared types and constants for the clock/reset-generator control block.
// Channel and select FSM encodings, channel indices and a counter-width helper.
package crg_ctrl_pkg;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_WAKE = 2'd1,
        CH_ON   = 2'd2,
        CH_HOLD = 2'd3
    } ch_state_e;

    typedef enum logic [1:0] {
        SW_IDLE = 2'd0,
        SW_GATE = 2'd1,
        SW_SWAP = 2'd2,
        SW_WAIT = 2'd3
    } sel_state_e;

    localparam int CH_PHY = 0;
    localparam int CH_1   = 1;
    localparam int CH_2   = 2;
    localparam int CH_3   = 3;

    // Counters saturate at their terminal value, so one extra bit covers it.
    function automatic int cnt_w(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/crg_ctrl_if.sv
// Request/select bus between the clock consumers and crg_ctrl.
// req/ack is a level handshake: req held high asks for the clock, ack high means it runs;
// sel_req is a single-cycle pulse honoured only while sel_busy is low.
interface crg_ctrl_if #(
    parameter int N_CLK = 4
);

    logic [N_CLK-1:0] req;
    logic [N_CLK-1:0] ack;
    logic [N_CLK-1:0] clk_en;
    logic             sel_req;
    logic             sel_target;
    logic             sel_busy;
    logic             clk1_sel;

    modport master (
        output req,
        output sel_req,
        output sel_target,
        input  ack,
        input  clk_en,
        input  sel_busy,
        input  clk1_sel
    );

    modport slave (
        input  req,
        input  sel_req,
        input  sel_target,
        output ack,
        output clk_en,
        output sel_busy,
        output clk1_sel
    );

endinterface

// File: rtl/crg_ch_gate.sv
// Single clock-channel gate: wakes on request, acks after a settle time and
// drops the enable only after a run of idle cycles; force_off_i parks it in OFF.
module crg_ch_gate
    import crg_ctrl_pkg::*;
#(
    parameter int EN_LAT   = 4,
    parameter int IDLE_CYC = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       force_off_i,
    output logic       clk_en_o,
    output logic       ack_o,
    output logic [1:0] state_o
);

    localparam int SW = cnt_w(EN_LAT);
    localparam int IW = cnt_w(IDLE_CYC);
    localparam logic [SW-1:0] SETTLE_END = SW'(EN_LAT);
    localparam logic [IW-1:0] IDLE_END   = IW'(IDLE_CYC);

    ch_state_e       state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [IW-1:0]   idle_q, idle_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        idle_d   = idle_q;
        if (force_off_i) begin
            state_d  = CH_OFF;
            settle_d = '0;
            idle_d   = '0;
        end else begin
            case (state_q)
                CH_OFF: begin
                    if (req_i) begin
                        state_d  = CH_WAKE;
                        settle_d = SW'(1);
                    end
                end
                // req is deliberately ignored while settling.
                CH_WAKE: begin
                    if (settle_q == SETTLE_END) begin
                        state_d  = CH_ON;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                CH_ON: begin
                    if (!req_i) begin
                        state_d = CH_HOLD;
                        idle_d  = IW'(1);
                    end
                end
                CH_HOLD: begin
                    if (req_i) begin
                        state_d = CH_ON;
                        idle_d  = '0;
                    end else if (idle_q == IDLE_END) begin
                        state_d = CH_OFF;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
                default: begin
                    state_d  = CH_OFF;
                    settle_d = '0;
                    idle_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= CH_OFF;
            settle_q <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idle_q   <= idle_d;
        end
    end

    // The force masks the outputs in the same cycle it is raised.
    assign clk_en_o = (state_q != CH_OFF) && !force_off_i;
    assign ack_o    = ((state_q == CH_ON) || (state_q == CH_HOLD)) && !force_off_i;
    assign state_o  = state_q;

endmodule

// File: rtl/crg_ctrl.sv
// Control side of the clock/reset generator: per-channel enable/ack FSMs plus
// a glitch-safe source-select sequencer for the selectable channel.
module crg_ctrl
    import crg_ctrl_pkg::*;
#(
    parameter int N_CLK    = 4,
    parameter int SEL_IDX  = CH_1,
    parameter int EN_LAT   = 4,
    parameter int IDLE_CYC = 16,
    parameter int SW_GAP   = 3
) (
    input  logic               clk_src,
    input  logic               rst_clk_src,
    crg_ctrl_if.slave          bus,
    output logic [2*N_CLK-1:0] dbg_ch_state_o,
    output logic [1:0]         dbg_sel_state_o
);

    localparam int GW = cnt_w(SW_GAP);
    localparam logic [GW-1:0] GAP_END = GW'(SW_GAP);

    if (EN_LAT < 1 || EN_LAT > 255 || IDLE_CYC < 1 || IDLE_CYC > 65535 ||
        SW_GAP < 1 || SW_GAP > 255 || SEL_IDX < 0 || SEL_IDX >= N_CLK) begin : g_bad_param
        $error("crg_ctrl: parameter out of range");
    end

    sel_state_e      sel_state_q, sel_state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            tgt_q, tgt_d;
    logic            clk1_sel_q, clk1_sel_d;
    logic            sel_release;
    logic            sel_force;
    logic [N_CLK-1:0] force_off;
    logic [N_CLK-1:0] clk_en_w;
    logic [N_CLK-1:0] ack_w;

    always_comb begin
        sel_state_d = sel_state_q;
        gap_d       = gap_q;
        tgt_d       = tgt_q;
        clk1_sel_d  = clk1_sel_q;
        case (sel_state_q)
            SW_IDLE: begin
                if (bus.sel_req && (bus.sel_target != clk1_sel_q)) begin
                    tgt_d       = bus.sel_target;
                    gap_d       = GW'(1);
                    sel_state_d = SW_GATE;
                end
            end
            SW_GATE: begin
                if (gap_q == GAP_END) begin
                    gap_d       = '0;
                    sel_state_d = SW_SWAP;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            SW_SWAP: begin
                clk1_sel_d  = tgt_q;
                gap_d       = GW'(1);
                sel_state_d = SW_WAIT;
            end
            SW_WAIT: begin
                if (gap_q == GAP_END) begin
                    gap_d       = '0;
                    sel_state_d = SW_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                gap_d       = '0;
                sel_state_d = SW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_src) begin
        if (rst_clk_src) begin
            sel_state_q <= SW_IDLE;
            gap_q       <= '0;
            tgt_q       <= 1'b0;
            clk1_sel_q  <= 1'b0;
        end else begin
            sel_state_q <= sel_state_d;
            gap_q       <= gap_d;
            tgt_q       <= tgt_d;
            clk1_sel_q  <= clk1_sel_d;
        end
    end

    // Releasing in the last busy cycle lets the channel re-enter WAKE exactly
    // as sel_busy falls, while its outputs stay low for the whole busy window.
    assign sel_release = (sel_state_q == SW_WAIT) && (gap_q == GAP_END);
    assign sel_force   = (sel_state_q != SW_IDLE) && !sel_release;

    always_comb begin
        force_off          = '0;
        force_off[SEL_IDX] = sel_force;
    end

    for (genvar g = 0; g < N_CLK; g++) begin : g_ch
        crg_ch_gate #(
            .EN_LAT   (EN_LAT),
            .IDLE_CYC (IDLE_CYC)
        ) u_gate (
            .clk_i       (clk_src),
            .rst_i       (rst_clk_src),
            .req_i       (bus.req[g]),
            .force_off_i (force_off[g]),
            .clk_en_o    (clk_en_w[g]),
            .ack_o       (ack_w[g]),
            .state_o     (dbg_ch_state_o[2*g +: 2])
        );
    end

    assign bus.clk_en       = clk_en_w;
    assign bus.ack          = ack_w;
    assign bus.sel_busy     = (sel_state_q != SW_IDLE);
    assign bus.clk1_sel     = clk1_sel_q;
    assign dbg_sel_state_o  = sel_state_q;

endmodule

// File: tb/tb_crg_ctrl.sv
// Bench for crg_ctrl: a timed vector table, hand-written corner sequences and a
// randomized run checked against a cycle-count reference model.
module tb_crg_ctrl;

    localparam int N_CLK    = 4;
    localparam int SEL_IDX  = 1;
    localparam int EN_LAT   = 4;
    localparam int IDLE_CYC = 16;
    localparam int SW_GAP   = 3;
    localparam int W        = 2*N_CLK + 2;
    localparam int N_RAND   = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crg_ctrl_if #(.N_CLK(N_CLK)) bus ();
    logic [2*N_CLK-1:0] dbg_ch;
    logic [1:0]         dbg_sel;

    crg_ctrl #(
        .N_CLK    (N_CLK),
        .SEL_IDX  (SEL_IDX),
        .EN_LAT   (EN_LAT),
        .IDLE_CYC (IDLE_CYC),
        .SW_GAP   (SW_GAP)
    ) dut (
        .clk_src         (clk),
        .rst_clk_src     (rst),
        .bus             (bus),
        .dbg_ch_state_o  (dbg_ch),
        .dbg_sel_state_o (dbg_sel)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        int         cyc;
        logic [3:0] req;
        logic       sreq;
        logic       stgt;
        logic [3:0] en;
        logic [3:0] ack;
        logic       busy;
        logic       sel;
    } vec_t;
    vec_t vecs[$];

    // Reference model state: enable flag, cycles since enable rose, consecutive
    // low request samples while acked, and position inside the select window.
    bit   m_en[N_CLK];
    int   m_age[N_CLK];
    int   m_low[N_CLK];
    int   m_bt;
    logic m_sel;
    logic m_tgt;

    function automatic vec_t mk(input int c, input logic [3:0] r, input logic sq, input logic st,
                                input logic [3:0] en, input logic [3:0] ack, input logic b,
                                input logic s);
        vec_t v;
        v.cyc = c; v.req = r; v.sreq = sq; v.stgt = st;
        v.en = en; v.ack = ack; v.busy = b; v.sel = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.sel_req = 1'b0;
    endtask

    function automatic logic [W-1:0] outs();
        return {bus.clk_en, bus.ack, bus.sel_busy, bus.clk1_sel};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CLK; i++) begin
            m_en[i] = 1'b0; m_age[i] = 0; m_low[i] = 0;
        end
        m_bt = 0; m_sel = 1'b0; m_tgt = 1'b0;
    endtask

    function automatic bit model_forced();
        return (m_bt >= 1) && (m_bt <= 2*SW_GAP);
    endfunction

    function automatic logic [W-1:0] model_outs();
        logic [N_CLK-1:0] en, ack;
        for (int i = 0; i < N_CLK; i++) begin
            en[i]  = m_en[i] && !(i == SEL_IDX && model_forced());
            ack[i] = en[i] && (m_age[i] >= EN_LAT);
        end
        return {en, ack, (m_bt != 0), m_sel};
    endfunction

    task automatic model_step(input logic [N_CLK-1:0] r, input logic sq, input logic st);
        bit forced;
        forced = model_forced();
        for (int i = 0; i < N_CLK; i++) begin
            if (i == SEL_IDX && forced) begin
                m_en[i] = 1'b0; m_age[i] = 0; m_low[i] = 0;
            end else if (!m_en[i]) begin
                if (r[i]) begin
                    m_en[i] = 1'b1; m_age[i] = 0; m_low[i] = 0;
                end
            end else if (m_age[i] < EN_LAT) begin
                m_age[i]++;
            end else if (r[i]) begin
                m_low[i] = 0;
            end else begin
                m_low[i]++;
                if (m_low[i] == IDLE_CYC + 1) begin
                    m_en[i] = 1'b0; m_low[i] = 0;
                end
            end
        end
        if (m_bt == 0) begin
            if (sq && (st != m_sel)) begin
                m_tgt = st; m_bt = 1;
            end
        end else begin
            if (m_bt == SW_GAP + 1) m_sel = m_tgt;
            m_bt = (m_bt == 2*SW_GAP + 1) ? 0 : m_bt + 1;
        end
    endtask

    initial begin
        logic [N_CLK-1:0] rreq;
        logic             rsq, rst_tgt;

        bus.req = '0; bus.sel_req = 1'b0; bus.sel_target = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_dbg_sel", 32'(dbg_sel), 32'd0);
        rst = 1'b0;
        cyc = 0;

        //            cyc  req      sq    st    en       ack      busy  sel
        vecs.push_back(mk(  0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk( 10, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk( 11, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk( 14, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk( 15, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 20, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 36, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 37, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk( 40, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk( 41, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk( 45, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 50, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 55, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 60, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 70, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 86, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 87, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk( 90, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk(106, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk(107, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk(110, 4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk(111, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk(115, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0, 1'b0));
        vecs.push_back(mk(120, 4'b0110, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0));
        vecs.push_back(mk(121, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0));
        vecs.push_back(mk(124, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0));
        vecs.push_back(mk(125, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1));
        vecs.push_back(mk(127, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1));
        vecs.push_back(mk(128, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b1));
        vecs.push_back(mk(131, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b1));
        vecs.push_back(mk(132, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0, 1'b1));
        vecs.push_back(mk(140, 4'b0110, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0, 1'b1));
        vecs.push_back(mk(141, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0, 1'b1));
        vecs.push_back(mk(150, 4'b0110, 1'b1, 1'b0, 4'b0110, 4'b0110, 1'b0, 1'b1));
        vecs.push_back(mk(151, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1));
        vecs.push_back(mk(154, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1));
        vecs.push_back(mk(155, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0));
        vecs.push_back(mk(156, 4'b0110, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0));
        vecs.push_back(mk(157, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0));
        vecs.push_back(mk(158, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk(159, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b0));
        vecs.push_back(mk(162, 4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cyc) tick();
            chk($sformatf("v%0d_clk_en", i), 32'(bus.clk_en), 32'(vecs[i].en));
            chk($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(vecs[i].ack));
            chk($sformatf("v%0d_busy", i), 32'(bus.sel_busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_sel", i), 32'(bus.clk1_sel), 32'(vecs[i].sel));
            bus.req        = vecs[i].req;
            bus.sel_req    = vecs[i].sreq;
            bus.sel_target = vecs[i].stgt;
        end

        // Reset landing in the middle of the post-swap wait.
        bus.sel_target = 1'b1;
        bus.sel_req    = 1'b1;
        tick();
        repeat (5) tick();
        chk("mid_wait_busy", 32'(bus.sel_busy), 32'd1);
        chk("mid_wait_sel", 32'(bus.clk1_sel), 32'd1);
        chk("mid_wait_en1_low", 32'(bus.clk_en[1]), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_mid_wait_outs", 32'(outs()), 32'd0);
        bus.req = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(outs()), 32'd0);

        // All four channels requested in the same cycle.
        bus.req = 4'b1111;
        tick();
        chk("all4_en", 32'(bus.clk_en), 32'hf);
        chk("all4_ack_early", 32'(bus.ack), 32'h0);
        repeat (EN_LAT - 1) tick();
        chk("all4_ack_late", 32'(bus.ack), 32'h0);
        tick();
        chk("all4_ack", 32'(bus.ack), 32'hf);
        chk("all4_en_hold", 32'(bus.clk_en), 32'hf);

        // Randomized run against the reference model, starting from reset.
        rst = 1'b1;
        bus.req = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        rreq = '0;
        exp_q.push_back(model_outs());
        for (int n = 0; n < N_RAND; n++) begin
            chk("rand_outs", 32'(outs()), 32'(exp_q.pop_front()));
            for (int b = 0; b < N_CLK; b++)
                if ($urandom_range(0, 23) == 0) rreq[b] = ~rreq[b];
            rsq     = ($urandom_range(0, 29) == 0);
            rst_tgt = 1'($urandom_range(0, 1));
            bus.req        = rreq;
            bus.sel_req    = rsq;
            bus.sel_target = rst_tgt;
            model_step(rreq, rsq, rst_tgt);
            exp_q.push_back(model_outs());
            tick();
        end
        chk("rand_final", 32'(outs()), 32'(exp_q.pop_front()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crg_ctrl.md
Name: crg_ctrl

Overview:
- Control-side companion of the clock/reset generator: produces the per-clock enable bits (clk_phy_en, clk1_en, clk2_en, clk3_en, packed as a vector) and the clk1 source select that the CRG consumes.
- Each clock channel is turned on when a consumer requests it, acknowledged after a settle time, and turned off after an idle hysteresis.
- Source-select changes on the selectable channel run a glitch-safe sequence: gate off, swap select, settle, re-enable.

Parameters:
- N_CLK, 4, number of gated clock channels (bit 0 = clk_phy, 1 = clk1, 2 = clk2, 3 = clk3).
- SEL_IDX, 1, index of the channel that has a source select.
- EN_LAT, 4, cycles from enable assertion to ack (CRG settle time); legal range 1..255.
- IDLE_CYC, 16, cycles of continuous req low before the enable is dropped; legal range 1..65535.
- SW_GAP, 3, cycles held on each side of a select change; legal range 1..255.

Ports:
- clk_src  input  1  free-running source clock; all logic in this domain.
- rst_clk_src  input  1  synchronous reset, active-high.
- req  input  N_CLK  per-channel clock request, level.
- ack  output  N_CLK  per-channel clock-running indication.
- clk_en  output  N_CLK  enables to the CRG.
- sel_req  input  1  one-cycle pulse requesting a select change.
- sel_target  input  1  requested select value, sampled on sel_req.
- sel_busy  output  1  high while a select sequence is in progress.
- clk1_sel  output  1  select to the CRG.

Behaviour:
- Reset values: clk_en=0, ack=0, clk1_sel=0, sel_busy=0. All counters clear and all FSMs go to OFF / SW_IDLE. Reset wins over every other event in the same cycle.

Per-channel FSM (one per channel):
- OFF: clk_en=0, ack=0. If req=1, go to WAKE next cycle with clk_en=1 in that same next cycle.
- WAKE: clk_en=1, ack=0. The counter counts EN_LAT cycles, then the channel goes to ON. Ack rises exactly EN_LAT cycles after clk_en rises. A req drop during WAKE is ignored; the channel completes to ON and then the normal idle rules apply.
- ON: clk_en=1, ack=1. If req=0, go to HOLD; the idle counter loads 1.
- HOLD: clk_en=1, ack=1. If req=1, return to ON and clear the counter. Otherwise the counter increments; when it reaches IDLE_CYC, go to OFF with clk_en=0 and ack=0 on the following cycle.
- Net timing: the enable drops IDLE_CYC+1 cycles after req falls.
- OFF to WAKE re-entry is allowed on the cycle immediately after the enable drops.

Select FSM (acts on channel SEL_IDX):
- SW_IDLE: sel_busy=0. A sel_req with sel_target==clk1_sel is discarded (no-op; sel_busy stays 0). A sel_req with sel_target!=clk1_sel latches the target and moves to SW_GATE.
- SW_GATE: sel_busy=1. clk_en[SEL_IDX] and ack[SEL_IDX] are forced to 0 and the channel FSM is held in OFF. Wait SW_GAP cycles, then go to SW_SWAP.
- SW_SWAP: clk1_sel takes the latched target for one cycle, then go to SW_WAIT.
- SW_WAIT: wait SW_GAP cycles, then return to SW_IDLE and release the channel FSM.
- On release, if req[SEL_IDX]=1 the channel enters WAKE (full EN_LAT before ack). Otherwise it stays OFF.
- sel_req pulses arriving while sel_busy=1 are dropped; the requester must wait for sel_busy=0.
- clk1_sel never changes while clk_en[SEL_IDX]=1.
- Total busy time: 2*SW_GAP+1 cycles.

General:
- Channels other than SEL_IDX are never affected by the select FSM.
- Simultaneous requests on all channels are handled independently in the same cycle.
- Counter widths: $clog2 of the parameter plus 1. No wrap is possible because counters stop at their terminal value.

Decomposition:
- Package crg_ctrl_pkg holds:
  - channel state enum (OFF, WAKE, ON, HOLD);
  - select state enum (SW_IDLE, SW_GATE, SW_SWAP, SW_WAIT);
  - channel index constants CH_PHY, CH_1, CH_2, CH_3.
- One sub-module, crg_ch_gate: a single-channel FSM with idle/settle counters and a force_off input. It is instantiated N_CLK times by a generate loop.
- The select FSM lives in the top module and drives force_off[SEL_IDX].

Test Plan:
- Wake: after reset, req[2]=1 at cycle 10 -> clk_en[2]=1 at cycle 11, ack[2]=1 at cycle 15 (EN_LAT=4). All other outputs stay 0.
- Idle hysteresis: with ch2 ON, req[2]=0 at cycle 20 -> clk_en[2] and ack[2] fall at cycle 37.
- Glitchy request: req[2] pulsed low for 5 cycles in ON -> no enable drop. A second test drops req at cycle 20 and re-raises it at cycle 36 -> stays ON, counter cleared.
- Select switch with req[1]=1 and ON, sel_req/sel_target=1 at cycle 50:
  - sel_busy=1 cycles 51–57;
  - clk_en[1]=0 from 51;
  - clk1_sel=1 at 55;
  - clk_en[1]=1 at 58, ack[1] returns at 62.
- Edge requests:
  - sel_req with sel_target equal to the current select -> no change, sel_busy stays 0.
  - sel_req during sel_busy -> dropped.
  - Reset asserted mid-SW_WAIT -> all outputs 0 next cycle, clk1_sel=0.
- All four reqs raised in the same cycle -> all acks rise together EN_LAT cycles after their enables.
